// File: rtl/des_iter_core.sv
// des_iter_core: iterative DES block engine evaluating ROUNDS_PER_CYCLE rounds per clock.
// Handshake: in_valid/in_ready accepts a block in IDLE, out_valid/out_ready drains it in DONE.
// Optional feature macro DES_ITER_DECRYPT_EN: when defined, in_dec selects decryption
// (reverse key schedule). When undefined the core always encrypts and in_dec is ignored.
module des_iter_core #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_dec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    localparam int unsigned N        = 16 / ROUNDS_PER_CYCLE;
    localparam logic [4:0]  STEP     = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0]  LAST_CNT = 5'(ROUNDS_PER_CYCLE * (N - 1));

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
        $error("des_iter_core: illegal ROUNDS_PER_CYCLE=%0d (legal: 1,2,4,8,16)",
               ROUNDS_PER_CYCLE);
    end

    // Permutation tables in DES numbering (bit 1 = MSB of the source vector)
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // S-boxes flattened as box*64 + row*16 + column
    localparam int SBOX [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63-i] = x[64-IP_T[i]];
        return r;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63-i] = x[64-FP_T[i]];
        return r;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = x[32-E_T[i]];
        return r;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[31-i] = x[32-P_T[i]];
        return r;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = x[64-PC1_T[i]];
        return r;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = x[56-PC2_T[i]];
        return r;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [5:0]  b;
        logic [31:0] s;
        x = perm_e(r) ^ k;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            b = x[47-6*i -: 6];
            // Outer bits pick the row, inner four bits the column
            s[31-4*i -: 4] = 4'(SBOX[64*i + 16*int'({b[5], b[0]}) + int'(b[4:1])]);
        end
        return perm_p(s);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

`ifdef DES_ITER_DECRYPT_EN
    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction
`endif

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [4:0]  cnt_q;
    logic [63:0] out_q;
    logic [31:0] round_l, round_r;
    logic [27:0] round_c, round_d;
    logic        last_round;

`ifdef DES_ITER_DECRYPT_EN
    logic dec_q;
`else
    logic unused_in_dec;
    assign unused_in_dec = in_dec;
`endif

    assign last_round = (cnt_q == LAST_CNT);

    // Chain ROUNDS_PER_CYCLE rounds of Feistel network and key schedule from the held state
    always_comb begin
        logic [31:0] l, r, t;
        logic [27:0] c, d;
        logic [47:0] sk;
        logic [4:0]  rnd;
        logic        one;
        l   = l_q;
        r   = r_q;
        c   = c_q;
        d   = d_q;
        t   = '0;
        sk  = '0;
        rnd = '0;
        one = 1'b0;
        for (int k = 0; k < int'(ROUNDS_PER_CYCLE); k++) begin
            rnd = cnt_q + 5'(k);
`ifdef DES_ITER_DECRYPT_EN
            if (dec_q) begin
                // Use C/D as-is, then step back to the previous encrypt subkey position
                sk  = perm_pc2({c, d});
                one = (rnd == 5'd0) || (rnd == 5'd7) || (rnd == 5'd14) || (rnd == 5'd15);
                c   = rotr28(c, one);
                d   = rotr28(d, one);
            end else begin
                one = (rnd == 5'd0) || (rnd == 5'd1) || (rnd == 5'd8) || (rnd == 5'd15);
                c   = rotl28(c, one);
                d   = rotl28(d, one);
                sk  = perm_pc2({c, d});
            end
`else
            one = (rnd == 5'd0) || (rnd == 5'd1) || (rnd == 5'd8) || (rnd == 5'd15);
            c   = rotl28(c, one);
            d   = rotl28(d, one);
            sk  = perm_pc2({c, d});
`endif
            t = l ^ feistel(r, sk);
            l = r;
            r = t;
        end
        round_l = l;
        round_r = r;
        round_c = c;
        round_d = d;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)   state_d = StRound;
            StRound: if (last_round) state_d = StDone;
            StDone:  if (out_ready)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // Datapath: load on accept, iterate in ROUND, capture the result on the last round
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q   <= '0;
            r_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
            out_q <= '0;
`ifdef DES_ITER_DECRYPT_EN
            dec_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        {l_q, r_q} <= perm_ip(in_data);
                        {c_q, d_q} <= perm_pc1(in_key);
                        cnt_q      <= '0;
`ifdef DES_ITER_DECRYPT_EN
                        dec_q      <= in_dec;
`endif
                    end
                end
                StRound: begin
                    l_q   <= round_l;
                    r_q   <= round_r;
                    c_q   <= round_c;
                    d_q   <= round_d;
                    cnt_q <= cnt_q + STEP;
                    // No final swap: preoutput is {R16, L16}
                    if (last_round) out_q <= perm_fp({round_r, round_l});
                end
                default: ;
            endcase
        end
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_des_iter_core.sv
// Bench for des_iter_core: constant vectors, stall/reset sequences and random blocks
// checked against a table-driven DES reference model. Two instances: 1 and 4 rounds/clock.
module tb_des_iter_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data, in_key;
    logic        in_dec;
    logic        in_valid1, in_valid4, out_ready1, out_ready4;
    logic        in_ready1, in_ready4, out_valid1, out_valid4;
    logic [63:0] out_data1, out_data4;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    des_iter_core #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data), .in_key(in_key), .in_dec(in_dec), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_data(out_data1));

    des_iter_core #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data), .in_key(in_key), .in_dec(in_dec), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_data(out_data4));

    // ---------------- reference model ----------------
    int IP_T[$] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    int FP_T[$] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    int E_T[$] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15,
                   16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27,
                   28, 29, 28, 29, 30, 31, 32, 1};
    int P_T[$] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                   2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    int PC1_T[$] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                     10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                     14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    int PC2_T[$] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8,
                     16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                     44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int SHIFTS[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int SB[8][4][16] = '{
        '{'{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
          '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
          '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
          '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}},
        '{'{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10},
          '{3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5},
          '{0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15},
          '{13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9}},
        '{'{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8},
          '{13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1},
          '{13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7},
          '{1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12}},
        '{'{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15},
          '{13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9},
          '{10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4},
          '{3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14}},
        '{'{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9},
          '{14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6},
          '{4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14},
          '{11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3}},
        '{'{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11},
          '{10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8},
          '{9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6},
          '{4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13}},
        '{'{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1},
          '{13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6},
          '{1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2},
          '{6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12}},
        '{'{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7},
          '{1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2},
          '{7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8},
          '{2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}}};

    // Generic permutation: output bit i (1-based, MSB first) takes input bit tab[i]
    function automatic logic [63:0] permute(input logic [63:0] x, input int iw, input int tab[$]);
        logic [63:0] r;
        int          ow;
        r  = '0;
        ow = tab.size();
        for (int i = 0; i < ow; i++) r[ow-1-i] = x[iw-tab[i]];
        return r;
    endfunction

    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] data,
                                            input logic dec);
        logic [63:0] tmp;
        logic [27:0] c, d;
        logic [47:0] ks[16];
        logic [47:0] e;
        logic [31:0] l, r, t, fo;
        logic [5:0]  six;
        tmp = permute(key, 64, PC1_T);
        c   = tmp[55:28];
        d   = tmp[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < SHIFTS[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            tmp   = permute({8'h00, c, d}, 56, PC2_T);
            ks[i] = tmp[47:0];
        end
        tmp = permute(data, 64, IP_T);
        l   = tmp[63:32];
        r   = tmp[31:0];
        for (int i = 0; i < 16; i++) begin
            tmp = permute({32'h0, r}, 32, E_T);
            e   = tmp[47:0] ^ (dec ? ks[15-i] : ks[i]);
            fo  = '0;
            for (int s = 0; s < 8; s++) begin
                six = e[47-6*s -: 6];
                fo[31-4*s -: 4] = 4'(SB[s][{six[5], six[0]}][six[4:1]]);
            end
            tmp = permute({32'h0, fo}, 32, P_T);
            t   = l ^ tmp[31:0];
            l   = r;
            r   = t;
        end
        return permute({r, l}, 64, FP_T);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 0) ? in_ready1 : in_ready4;
    endfunction

    function automatic logic vld(input int w);
        return (w == 0) ? out_valid1 : out_valid4;
    endfunction

    function automatic logic [63:0] dout(input int w);
        return (w == 0) ? out_data1 : out_data4;
    endfunction

    task automatic set_valid(input int w, input logic v);
        if (w == 0) in_valid1 = v;
        else        in_valid4 = v;
    endtask

    task automatic set_ready(input int w, input logic v);
        if (w == 0) out_ready1 = v;
        else        out_ready4 = v;
    endtask

    task automatic scramble();
        in_key  = {$urandom, $urandom};
        in_data = {$urandom, $urandom};
        in_dec  = 1'($urandom);
    endtask

    // Run one block through instance w; all sampling happens 1ns after a rising edge
    task automatic send(input int w, input logic [63:0] k, input logic [63:0] d, input logic dc,
                        input logic [63:0] exp, input int stall, input string nm);
        int lat;
        lat = 0;
        while (!rdy(w) && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        in_key  = k;
        in_data = d;
        in_dec  = dc;
        set_valid(w, 1'b1);
        set_ready(w, 1'b0);
        @(posedge clk); #1;
        lat = 0;
        // Inputs churn and in_valid stays high while busy: none of it may be sampled
        while (!vld(w) && lat < 64) begin
            scramble();
            @(posedge clk); #1;
            lat++;
        end
        set_valid(w, 1'b0);
        check({nm, " latency"}, 64'(lat), (w == 0) ? 64'd16 : 64'd4);
        check({nm, " data"}, dout(w), exp);
        for (int i = 0; i < stall; i++) begin
            set_valid(w, 1'($urandom));
            scramble();
            @(posedge clk); #1;
            check({nm, " stall data"}, dout(w), exp);
            check({nm, " stall in_ready"}, 64'(rdy(w)), 64'd0);
            check({nm, " stall out_valid"}, 64'(vld(w)), 64'd1);
        end
        set_valid(w, 1'b0);
        set_ready(w, 1'b1);
        @(posedge clk); #1;
        check({nm, " release in_ready"}, 64'(rdy(w)), 64'd1);
        check({nm, " release out_valid"}, 64'(vld(w)), 64'd0);
        set_ready(w, 1'b0);
    endtask

    typedef struct {
        logic [63:0] key;
        logic [63:0] data;
        logic        dec;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [63:0] k, d, exp;
        logic        dc, dc_eff;
        int          bad;

        vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
        vecs[1] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
        vecs[2] = '{64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h7359B2163E4EDC58};
        vecs[4] = '{64'h0123456789ABCDEF, 64'h4E6F772069732074, 1'b0, 64'h3FA40E8A984D4815};
`ifdef DES_ITER_DECRYPT_EN
        vecs[5] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
        vecs[6] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};
`else
        // in_dec must be ignored: still an encryption
        vecs[5] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b1, 64'h85E813540F0AB405};
        vecs[6] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b1, 64'h0000000000000000};
`endif

        rst_n      = 1'b0;
        in_valid1  = 1'b0;
        in_valid4  = 1'b0;
        out_ready1 = 1'b0;
        out_ready4 = 1'b0;
        in_key     = '0;
        in_data    = '0;
        in_dec     = 1'b0;
        #12;
        check("reset in_ready1", 64'(in_ready1), 64'd1);
        check("reset out_valid1", 64'(out_valid1), 64'd0);
        check("reset out_data1", out_data1, 64'd0);
        check("reset in_ready4", 64'(in_ready4), 64'd1);
        check("reset out_valid4", 64'(out_valid4), 64'd0);
        check("reset out_data4", out_data4, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Constant vectors on both instances
        for (int i = 0; i < 7; i++) begin
            send(0, vecs[i].key, vecs[i].data, vecs[i].dec, vecs[i].exp, i % 3,
                 $sformatf("vec%0d rpc1", i));
            send(1, vecs[i].key, vecs[i].data, vecs[i].dec, vecs[i].exp, i % 2,
                 $sformatf("vec%0d rpc4", i));
        end

        // Long output stall with in_valid pulses
        send(0, vecs[0].key, vecs[0].data, 1'b0, vecs[0].exp, 10, "stall10");

        // Reset in the middle of a block
        in_key  = vecs[2].key;
        in_data = vecs[2].data;
        in_dec  = 1'b0;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset in_ready", 64'(in_ready1), 64'd1);
        check("midreset out_valid", 64'(out_valid1), 64'd0);
        check("midreset out_data", out_data1, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid1 || !in_ready1) bad++;
        end
        check("midreset no partial result", 64'(bad), 64'd0);
        send(0, vecs[0].key, vecs[0].data, 1'b0, vecs[0].exp, 0, "after reset");

        // Random blocks against the model
        for (int i = 0; i < 30; i++) begin
            k  = {$urandom, $urandom};
            d  = {$urandom, $urandom};
            dc = 1'($urandom);
`ifdef DES_ITER_DECRYPT_EN
            dc_eff = dc;
`else
            dc_eff = 1'b0;
`endif
            exp = des_ref(k, d, dc_eff);
            send(i % 2, k, d, dc, exp, int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
